// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared types for the kernel_pr start-propagation controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kernel_pr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

    localparam int MAX_INFLIGHT_DEF = 2;

    // The in-flight counter has to represent 0..max_inflight inclusive.
    function automatic int inflight_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/kernel_pr_start_ctrl_write_back_if.sv
// Start-FIFO read port, ap_ctrl_chain handshake and completion hand-off.
// Latency: n/a (wiring only).
// Backpressure: ap_ready gates start acceptance, done_rdy gates completion.
interface kernel_pr_start_ctrl_write_back_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_empty_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_done;
    logic                  ap_continue;
    logic [DATA_WIDTH-1:0] tok_dout;
    logic                  done_vld;
    logic                  done_rdy;

    modport master (
        input  if_empty_n, if_dout, ap_ready, ap_done, done_rdy,
        output if_read, if_read_ce, ap_start, ap_continue, tok_dout, done_vld
    );

    modport slave (
        output if_empty_n, if_dout, ap_ready, ap_done, done_rdy,
        input  if_read, if_read_ce, ap_start, ap_continue, tok_dout, done_vld
    );
endinterface

// File: rtl/kernel_pr_sat_counter.sv
// Saturating up/down counter: clamps at MAX_VAL going up and at 0 going down.
// Latency: 1 cycle from inc/dec to cnt.
// Backpressure: none; simultaneous inc and effective dec cancel.
module kernel_pr_sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dec_ok;

    always_comb begin
        cnt_d  = cnt_q;
        // A decrement at zero is dropped rather than wrapping.
        dec_ok = dec & (cnt_q != '0);
        if (inc && !dec_ok && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_ok && !inc) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/kernel_pr_start_ctrl_write_back.sv
// Pops start tokens and drives ap_ctrl_chain of the write-back process; optional KERNEL_PR_START_CTRL_STATS_EN adds counters.
// Latency: pop to ap_start 1 cycle; one start per cycle sustained while room allows.
// Backpressure: ap_start/tok_dout held until ap_ready; pops stop on stop or when MAX_INFLIGHT is reached.
module kernel_pr_start_ctrl_write_back
    import kernel_pr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_WIDTH    = 32
) (
    input  logic clk,
    input  logic reset,
    kernel_pr_start_ctrl_write_back_if.master bus,
    input  logic stop,
    output logic idle
`ifdef KERNEL_PR_START_CTRL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_starts,
    output logic [CNT_WIDTH-1:0] stat_stall
`endif
);
    localparam int             IFW          = inflight_width(MAX_INFLIGHT);
    localparam logic [IFW-1:0] INFLIGHT_MAX = IFW'(MAX_INFLIGHT);
    localparam logic [IFW:0]   ROOM_LIMIT   = (IFW + 1)'(MAX_INFLIGHT);

    ctrl_state_e           state_q, state_d;
    logic                  ap_start_q, ap_start_d;
    logic [DATA_WIDTH-1:0] tok_q, tok_d;
    logic [IFW-1:0]        inflight_q;
    logic [IFW:0]          occupancy;
    logic                  accept, complete, room, pop, last_done;

    // An accepted token moves from held to in-flight, so occupancy is unchanged
    // by the accept itself; the token register is only free to reload when the
    // held token is empty or leaving this cycle.
    always_comb begin
        accept    = ap_start_q & bus.ap_ready;
        complete  = bus.ap_done & bus.done_rdy;
        occupancy = {1'b0, inflight_q} + {{IFW{1'b0}}, ap_start_q};
        room      = occupancy < ROOM_LIMIT;
        pop       = bus.if_empty_n & ~stop & room & (~ap_start_q | accept) & ~reset;
        last_done = complete & ~accept & (inflight_q == IFW'(1));
    end

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        if (pop) begin
            tok_d = bus.if_dout;
        end
        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d = ST_ARMED;
                end else if (stop && (inflight_q != '0) && !last_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ARMED: begin
                if (accept) begin
                    if (pop) begin
                        state_d = ST_ARMED;
                    end else if (stop) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop) begin
                    state_d = ST_ARMED;
                end else if (!stop || last_done) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        ap_start_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            ap_start_q <= 1'b0;
            tok_q      <= '0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= ap_start_d;
            tok_q      <= tok_d;
        end
    end

    kernel_pr_sat_counter #(
        .WIDTH   (IFW),
        .MAX_VAL (INFLIGHT_MAX)
    ) u_inflight (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .dec   (complete),
        .cnt   (inflight_q)
    );

`ifdef KERNEL_PR_START_CTRL_STATS_EN
    kernel_pr_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stat_starts (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .dec   (1'b0),
        .cnt   (stat_starts)
    );

    kernel_pr_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stat_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (ap_start_q & ~bus.ap_ready),
        .dec   (1'b0),
        .cnt   (stat_stall)
    );
`endif

    assign bus.if_read     = pop;
    assign bus.if_read_ce  = 1'b1;
    assign bus.ap_start    = ap_start_q;
    assign bus.tok_dout    = tok_q;
    assign bus.done_vld    = bus.ap_done;
    assign bus.ap_continue = bus.done_rdy;
    assign idle            = ~ap_start_q & (inflight_q == '0);
endmodule
